led_cmd_sequencer: RTL and testbench

- UART-driven controller that sequences the 4-LED display.
- Parses 2-byte command frames from the UART receiver: opcode byte, then argument byte.
- Holds mode, speed and pattern registers, generates the step tick, drives led[3:0], and returns a 1-byte ack/nak through the UART transmitter handshake.
- Sits between uart_rx/uart_tx and the board LEDs; replaces the free-running flow-LED function.

---
 rtl/led_cmd_pkg.sv | 46 ++++
 rtl/led_cmd_sequencer_tick_gen.sv | 52 +++++
 rtl/led_cmd_sequencer.sv | 147 ++++++++++++++
 tb/tb_led_cmd_sequencer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_cmd_pkg.sv
// Shared encodings for the UART-driven LED command sequencer.
// Opcodes, response bytes, modes and LED reload values.
package led_cmd_pkg;

  localparam logic [7:0] OP_MODE  = 8'h4D;
  localparam logic [7:0] OP_SPEED = 8'h53;
  localparam logic [7:0] OP_PAT   = 8'h50;

  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h45;
  localparam logic [7:0] RSP_TO  = 8'h54;

  localparam logic [7:0] MODE_MAX = 8'd4;

  typedef enum logic [2:0] {
    MODE_OFF    = 3'd0,
    MODE_FLOW_L = 3'd1,
    MODE_FLOW_R = 3'd2,
    MODE_BLINK  = 3'd3,
    MODE_STATIC = 3'd4
  } mode_e;

  typedef enum logic {
    ST_IDLE,
    ST_WAIT_ARG
  } state_e;

  localparam logic [3:0] LED_OFF    = 4'b0000;
  localparam logic [3:0] LED_FLOW_L = 4'b1000;
  localparam logic [3:0] LED_FLOW_R = 4'b0001;
  localparam logic [3:0] PAT_RST    = 4'b1000;

  function automatic logic [3:0] mode_reload(
    input mode_e      m,
    input logic [3:0] pat
  );
    case (m)
      MODE_FLOW_L: return LED_FLOW_L;
      MODE_FLOW_R: return LED_FLOW_R;
      MODE_BLINK:  return pat;
      MODE_STATIC: return pat;
      default:     return LED_OFF;
    endcase
  endfunction

endpackage

// File: rtl/led_cmd_sequencer_tick_gen.sv
// Base tick counter plus speed divider; step fires every
// (speed+1) base ticks, one cycle wide.
module tick_gen #(
  parameter logic [24:0] BASE_CNT = 25'd1_999_999
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [3:0] i_speed,
  input  logic       i_div_clr,
  output logic       o_step
);

  logic [24:0] r_base_cnt;
  logic        r_base_tick;
  logic [3:0]  r_div;
  logic        r_step;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_base_cnt  <= '0;
      r_base_tick <= 1'b0;
      r_div       <= '0;
      r_step      <= 1'b0;
    end else begin
      if (r_base_cnt == BASE_CNT) begin
        r_base_cnt  <= '0;
        r_base_tick <= 1'b1;
      end else begin
        r_base_cnt  <= r_base_cnt + 25'd1;
        r_base_tick <= 1'b0;
      end
      // A speed change restarts the step period from scratch
      if (i_div_clr) begin
        r_div  <= '0;
        r_step <= 1'b0;
      end else if (r_base_tick) begin
        if (r_div == i_speed) begin
          r_div  <= '0;
          r_step <= 1'b1;
        end else begin
          r_div  <= r_div + 4'd1;
          r_step <= 1'b0;
        end
      end else begin
        r_step <= 1'b0;
      end
    end
  end

  assign o_step = r_step;

endmodule

// File: rtl/led_cmd_sequencer.sv
// Parses 2-byte UART command frames, sequences the 4 LEDs
// and returns a 1-byte ack/nak through the tx handshake.
module led_cmd_sequencer
  import led_cmd_pkg::*;
#(
  parameter logic [24:0] BASE_CNT    = 25'd1_999_999,
  parameter logic [24:0] ARG_TIMEOUT = 25'd24_999_999
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       tx_busy,
  output logic [7:0] tx_data,
  output logic       tx_req,
  output logic [3:0] led
);

  state_e      r_state;
  logic [7:0]  r_opcode;
  logic [24:0] r_to_cnt;
  mode_e       r_mode;
  logic [3:0]  r_speed;
  logic [3:0]  r_pattern;
  logic [3:0]  r_led;
  logic        r_pend;
  logic [7:0]  r_pend_data;
  logic        r_tx_req;
  logic [7:0]  r_tx_data;

  logic       w_step;
  logic       w_exec;
  logic       w_hi_zero;
  logic       w_set_mode;
  logic       w_set_speed;
  logic       w_set_pat;
  logic       w_timeout;
  logic       w_rsp_vld;
  logic       w_launch;
  logic [7:0] w_rsp;
  logic [3:0] w_led_step;

  assign w_exec      = (r_state == ST_WAIT_ARG) && rx_valid;
  assign w_hi_zero   = (rx_data[7:4] == 4'd0);
  assign w_set_mode  = w_exec && (r_opcode == OP_MODE)
                     && (rx_data <= MODE_MAX);
  assign w_set_speed = w_exec && (r_opcode == OP_SPEED) && w_hi_zero;
  assign w_set_pat   = w_exec && (r_opcode == OP_PAT) && w_hi_zero;
  assign w_timeout   = (r_state == ST_WAIT_ARG) && !rx_valid
                     && (r_to_cnt == ARG_TIMEOUT);
  assign w_rsp_vld   = w_exec || w_timeout;
  assign w_launch    = r_pend && !tx_busy;

  always_comb begin
    w_rsp = RSP_ERR;
    unique case (1'b1)
      w_timeout:                         w_rsp = RSP_TO;
      w_set_mode, w_set_speed, w_set_pat: w_rsp = RSP_OK;
      default:                           w_rsp = RSP_ERR;
    endcase
  end

  always_comb begin
    w_led_step = r_led;
    case (r_mode)
      MODE_FLOW_L: w_led_step = {r_led[2:0], r_led[3]};
      MODE_FLOW_R: w_led_step = {r_led[0], r_led[3:1]};
      MODE_BLINK:  w_led_step = r_led ^ r_pattern;
      default:     w_led_step = r_led;
    endcase
  end

  tick_gen #(
    .BASE_CNT (BASE_CNT)
  ) u_tick (
    .i_clk     (sys_clk),
    .i_rst_n   (rst_n),
    .i_speed   (r_speed),
    .i_div_clr (w_set_speed),
    .o_step    (w_step)
  );

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_opcode    <= '0;
      r_to_cnt    <= '0;
      r_mode      <= MODE_OFF;
      r_speed     <= '0;
      r_pattern   <= PAT_RST;
      r_led       <= LED_OFF;
      r_pend      <= 1'b0;
      r_pend_data <= '0;
      r_tx_req    <= 1'b0;
      r_tx_data   <= '0;
    end else begin
      r_tx_req <= 1'b0;
      if (w_launch) begin
        r_tx_req  <= 1'b1;
        r_tx_data <= r_pend_data;
        r_pend    <= 1'b0;
      end
      // Single slot: a newer response replaces an unsent one
      if (w_rsp_vld) begin
        r_pend      <= 1'b1;
        r_pend_data <= w_rsp;
      end

      case (r_state)
        ST_IDLE: begin
          r_to_cnt <= '0;
          if (rx_valid) begin
            r_opcode <= rx_data;
            r_state  <= ST_WAIT_ARG;
          end
        end
        ST_WAIT_ARG: begin
          if (rx_valid || w_timeout) begin
            r_state  <= ST_IDLE;
            r_to_cnt <= '0;
          end else begin
            r_to_cnt <= r_to_cnt + 25'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_set_speed) r_speed   <= rx_data[3:0];
      if (w_set_pat)   r_pattern <= rx_data[3:0];

      // Reload beats a coincident step
      if (w_set_mode) begin
        r_mode <= mode_e'(rx_data[2:0]);
        r_led  <= mode_reload(mode_e'(rx_data[2:0]), r_pattern);
      end else if (r_mode == MODE_STATIC) begin
        r_led <= r_pattern;
      end else if (w_step) begin
        r_led <= w_led_step;
      end
    end
  end

  assign tx_req  = r_tx_req;
  assign tx_data = r_tx_data;
  assign led     = r_led;

endmodule

// File: tb/tb_led_cmd_sequencer.sv
// Bench for led_cmd_sequencer: cycle model plus
// directed command frames with literal expectations.
module tb_led_cmd_sequencer;

  localparam int BASE = 9;
  localparam int TOUT = 49;

  logic       sys_clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_busy;
  logic [7:0] tx_data;
  logic       tx_req;
  logic [3:0] led;

  led_cmd_sequencer #(
    .BASE_CNT    (25'd9),
    .ARG_TIMEOUT (25'd49)
  ) dut (
    .sys_clk  (sys_clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_busy  (tx_busy),
    .tx_data  (tx_data),
    .tx_req   (tx_req),
    .led      (led)
  );

  always #5 sys_clk = ~sys_clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Behavioural model state
  int         m_k, m_ticks, m_wait, m_mode;
  bit         m_waiting, m_step, m_pend, m_txreq;
  logic [7:0] m_op, m_pend_d, m_txd;
  logic [3:0] m_speed, m_pat, m_led;

  function automatic logic [3:0] rotl(input logic [3:0] v);
    int x = int'(v);
    return 4'((x * 2 + x / 8) % 16);
  endfunction

  function automatic logic [3:0] rotr(input logic [3:0] v);
    int x = int'(v);
    return 4'(x / 2 + (x % 2) * 8);
  endfunction

  task automatic model_reset();
    m_k = 0; m_ticks = 0; m_wait = 0; m_mode = 0;
    m_waiting = 0; m_step = 0; m_pend = 0; m_txreq = 0;
    m_op = 0; m_pend_d = 0; m_txd = 0;
    m_speed = 0; m_pat = 4'b1000; m_led = 0;
  endtask

  task automatic model_edge();
    bit         step_now, rsp, clr, reload, bt;
    logic [7:0] rv;
    logic [3:0] o_pat, o_speed;
    int         o_mode, nmode;
    step_now = m_step;
    o_pat = m_pat; o_speed = m_speed; o_mode = m_mode;
    nmode = m_mode;
    rsp = 0; clr = 0; reload = 0; rv = 8'h45;
    m_k++;
    if (!m_waiting) begin
      if (rx_valid) begin
        m_op = rx_data; m_waiting = 1; m_wait = 0;
      end
    end else if (rx_valid) begin
      m_waiting = 0; rsp = 1;
      if (m_op == 8'h4D && rx_data < 5) begin
        nmode = int'(rx_data); reload = 1; rv = 8'h4B;
      end else if (m_op == 8'h53 && rx_data < 16) begin
        m_speed = rx_data[3:0]; clr = 1; rv = 8'h4B;
      end else if (m_op == 8'h50 && rx_data < 16) begin
        m_pat = rx_data[3:0]; rv = 8'h4B;
      end
    end else begin
      m_wait++;
      if (m_wait == TOUT + 1) begin
        m_waiting = 0; rsp = 1; rv = 8'h54;
      end
    end
    m_txreq = 0;
    if (m_pend && !tx_busy) begin
      m_txreq = 1; m_txd = m_pend_d; m_pend = 0;
    end
    if (rsp) begin
      m_pend = 1; m_pend_d = rv;
    end
    bt = (m_k > BASE + 1) && ((m_k - 1) % (BASE + 1) == 0);
    m_step = 0;
    if (clr) m_ticks = 0;
    else if (bt) begin
      m_ticks++;
      if (m_ticks == int'(o_speed) + 1) begin
        m_step = 1; m_ticks = 0;
      end
    end
    if (reload) begin
      case (nmode)
        1: m_led = 4'b1000;
        2: m_led = 4'b0001;
        3, 4: m_led = o_pat;
        default: m_led = 4'b0000;
      endcase
    end else if (o_mode == 4) m_led = o_pat;
    else if (step_now) begin
      case (o_mode)
        1: m_led = rotl(m_led);
        2: m_led = rotr(m_led);
        3: m_led = m_led ^ o_pat;
        default: m_led = m_led;
      endcase
    end
    m_mode = nmode;
  endtask

  // Logs of DUT activity for the directed checks
  logic [3:0] lv[$];
  int         lt[$];
  int         cyc = 0;
  logic [3:0] prev_led = 4'b0000;
  int         tx_cnt = 0;
  logic [7:0] tx_last = 8'h00;

  initial model_reset();

  always @(posedge sys_clk) begin
    if (!rst_n) model_reset();
    else model_edge();
    #1;
    chk("led", led, m_led);
    chk("tx_req", tx_req, m_txreq);
    chk("tx_data", tx_data, m_txd);
    cyc++;
    if (rst_n) begin
      if (led !== prev_led) begin
        lv.push_back(led);
        lt.push_back(cyc);
      end
      if (tx_req) begin
        tx_cnt++;
        tx_last = tx_data;
      end
    end
    prev_led = led;
  end

  function automatic logic [3:0] logv(input int i);
    if (lv.size() > i) return lv[i];
    return 4'bxxxx;
  endfunction

  function automatic int gap(input int i);
    if (lt.size() > i) return lt[i] - lt[i-1];
    return -1;
  endfunction

  task automatic clr_log();
    lv.delete();
    lt.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge sys_clk);
    rx_valid = 1'b0;
  endtask

  task automatic frame(input logic [7:0] op, input logic [7:0] arg);
    send_byte(op);
    send_byte(arg);
    idle(3);
  endtask

  int t0;

  initial begin
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_busy = 1'b0;
    repeat (3) @(negedge sys_clk);
    rst_n = 1'b1;
    chk("rst_led", led, 4'b0000);
    idle(500);
    chk("rst_no_tx", tx_cnt, 0);

    t0 = tx_cnt;
    clr_log();
    frame(8'h4D, 8'h01);
    idle(40);
    chk("m1_tx_n", tx_cnt - t0, 1);
    chk("m1_tx_k", tx_last, 8'h4B);
    chk("m1_led0", logv(0), 4'b1000);
    chk("m1_led1", logv(1), 4'b0001);
    chk("m1_led2", logv(2), 4'b0010);
    chk("m1_gap", gap(2), 10);

    frame(8'h4D, 8'h00);
    t0 = tx_cnt;
    clr_log();
    frame(8'h53, 8'h03);
    frame(8'h4D, 8'h02);
    idle(100);
    chk("s3m2_tx_n", tx_cnt - t0, 2);
    chk("s3m2_tx_k", tx_last, 8'h4B);
    chk("s3m2_led0", logv(0), 4'b0001);
    chk("s3m2_led1", logv(1), 4'b1000);
    chk("s3m2_led2", logv(2), 4'b0100);
    chk("s3m2_gap", gap(2), 40);

    frame(8'h4D, 8'h00);
    frame(8'h53, 8'h00);
    clr_log();
    frame(8'h50, 8'h0A);
    frame(8'h4D, 8'h03);
    idle(30);
    chk("blink_led0", logv(0), 4'b1010);
    chk("blink_led1", logv(1), 4'b0000);
    chk("blink_led2", logv(2), 4'b1010);
    chk("blink_gap", gap(2), 10);
    t0 = tx_cnt;
    frame(8'h50, 8'h1A);
    chk("pbad_tx_n", tx_cnt - t0, 1);
    chk("pbad_tx_e", tx_last, 8'h45);
    frame(8'h4D, 8'h05);
    chk("mbad_tx_e", tx_last, 8'h45);
    frame(8'h58, 8'h00);
    chk("opbad_tx_e", tx_last, 8'h45);

    t0 = tx_cnt;
    send_byte(8'h4D);
    idle(55);
    chk("to_tx_n", tx_cnt - t0, 1);
    chk("to_tx_t", tx_last, 8'h54);
    frame(8'h4D, 8'h04);
    chk("m4_tx_k", tx_last, 8'h4B);
    chk("m4_led", led, 4'b1010);

    t0 = tx_cnt;
    send_byte(8'h50);
    idle(49);
    send_byte(8'h05);
    idle(3);
    chk("edge_tx_n", tx_cnt - t0, 1);
    chk("edge_tx_k", tx_last, 8'h4B);
    chk("edge_led", led, 4'b0101);

    tx_busy = 1'b1;
    t0 = tx_cnt;
    frame(8'h53, 8'h00);
    frame(8'h51, 8'h00);
    idle(5);
    chk("busy_hold", tx_cnt - t0, 0);
    tx_busy = 1'b0;
    idle(5);
    chk("busy_tx_n", tx_cnt - t0, 1);
    chk("busy_tx_e", tx_last, 8'h45);

    t0 = tx_cnt;
    send_byte(8'h4D);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(100);
    chk("rst_mid_tx", tx_cnt - t0, 0);
    chk("rst_mid_led", led, 4'b0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
